// File: rtl/instr_fetch.sv
// Instruction fetch: PC generation, one-outstanding imem requests, 2-entry
// {pc, data} buffer with valid/ready output, and redirect flush handling.
module instr_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, req_pc;
  logic [WIDTH-1:0] fifo_pc   [2];
  logic [WIDTH-1:0] fifo_data [2];
  logic             wptr, rptr;
  logic [1:0]       count;
  logic             push, pop, space, granted;

  assign space   = (count < 2'd2);
  assign pop     = instr_valid && instr_ready;
  assign granted = (state == REQ) && imem_gnt;

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (count != 2'd0);
  assign instr_data  = fifo_data[rptr];
  assign instr_pc    = fifo_pc[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A redirect never pushes: any response arriving with it belongs to the old path.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid || space) state_nxt = REQ;
      end
      REQ: begin
        if (imem_gnt) state_nxt = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          state_nxt = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          push      = 1'b1;
          state_nxt = (count == 2'd0 || (count == 2'd1 && pop)) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (imem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (redirect_valid) pc <= redirect_pc & ~(WIDTH'(3));
      else if (granted)   pc <= pc + WIDTH'(4);
      if (granted) req_pc <= pc;
    end
  end

  // Buffer control; a pop coinciding with a redirect is discarded by the flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else if (redirect_valid) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else if (push) begin
      fifo_pc[wptr]   <= req_pc;
      fifo_data[wptr] <= imem_rdata;
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the register-select stage in `riscv_top`. Generates the program counter, issues one-outstanding word requests to instruction memory, buffers returned words in a 2-entry FIFO and presents them with valid/ready to the next stage. `instr_data` drives that stage's 32-bit `addr` input. A redirect (branch/jump) flushes the buffer and any in-flight response.

## Interface
- `WIDTH`, 32, width of PC, memory address and instruction word
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- `clk`  in  1  clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `imem_req`  out  1  request valid to instruction memory
- `imem_addr`  out  WIDTH  word-aligned request address
- `imem_gnt`  in  1  request accepted this cycle (qualified by `imem_req`)
- `imem_rvalid`  in  1  read data valid, at least 1 cycle after grant
- `imem_rdata`  in  WIDTH  read data
- `redirect_valid`  in  1  PC redirect, single-cycle pulse
- `redirect_pc`  in  WIDTH  new PC; bits [1:0] ignored and treated as 0
- `instr_valid`  out  1  `instr_data`/`instr_pc` valid
- `instr_ready`  in  1  downstream accepts
- `instr_data`  out  WIDTH  fetched word, to register-select `addr`
- `instr_pc`  out  WIDTH  address of `instr_data`

## Operation
- State machine IDLE, REQ, WAIT, DROP. Reset state IDLE; `pc` = `RESET_PC`; FIFO empty.
- Space condition: FIFO `count` < 2 (current registered count; a same-cycle pop is not credited).
- IDLE: go REQ when space, else stay.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt`: latch `req_pc`=`pc`, `pc`<=`pc`+4 (wraps modulo 2^WIDTH), go WAIT.
- WAIT: on `imem_rvalid`: push {`req_pc`, `imem_rdata`}; go REQ if `count`+1 < 2 after push/pop accounting, else IDLE.
- DROP: on `imem_rvalid`: discard data, go REQ.
- `imem_rvalid` in IDLE or REQ is ignored.
- Redirect (highest priority):
  - `pc`<=`redirect_pc & ~3`; FIFO flushed (count 0, pointers 0).
  - REQ without gnt: stay REQ, new address appears next cycle (address may change before grant).
  - REQ with gnt same cycle: old request is in flight, go DROP.
  - WAIT without rvalid: go DROP. WAIT with rvalid same cycle: data discarded, go REQ.
  - DROP: stay DROP (one response still owed). With rvalid same cycle: go REQ.
  - IDLE: go REQ.
- FIFO: 2 entries, each {pc, data}. `instr_valid` = `count`≠0; `instr_data`/`instr_pc` = head entry. Pop on `instr_valid && instr_ready`. Push and pop in the same cycle keep `count` unchanged. Issue gating makes push-when-full impossible. Pop in a redirect cycle is lost with the flush.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr_data`=0, `instr_pc`=0. Storage cleared to 0.
- First `imem_req` in the 2nd cycle after `rst` deasserts (one IDLE cycle).
- `imem_addr` is stable while `imem_req`=1 and no redirect.
- Response latency: `instr_valid` rises the cycle after the `imem_rvalid` cycle.
- Back-to-back throughput, with gnt in 1 cycle and rvalid 1 cycle later: one word per 2 cycles.
- Redirect: `instr_valid`=0 the cycle after the redirect. The first word from `redirect_pc` is requested no earlier than that cycle.
- `rst` mid-operation forces the reset state immediately. Any in-flight memory response after reset is ignored (arrives in IDLE/REQ).

## Test plan
- Reset then gnt/rvalid each 1 cycle, `instr_ready`=1: `instr_pc` sequence 0x0, 0x4, 0x8. `instr_data` matches memory model words.
- `instr_ready`=0 for 10 cycles: `count` reaches 2, `imem_req` stays 0, `instr_valid` held. On release, 0x0 then 0x4 are popped and fetch resumes at 0x8.
- Redirect to 0x103 while in WAIT: the pending response (for 0x8) is dropped. Next `instr_pc` is 0x100. No stale word is ever presented.
- Redirect coincident with `imem_gnt` and with `imem_rvalid` (separate runs): DROP is entered / data is discarded respectively. First valid `instr_pc` is the redirect target.
- `imem_gnt` delayed 5 cycles: `imem_req` and `imem_addr` are stable throughout. A redirect on cycle 3 changes `imem_addr` to the new target next cycle.
- `rst` asserted mid-WAIT, rvalid arrives 2 cycles after deassert: it is ignored. The first fetch is `RESET_PC`. All outputs are at reset values during `rst`.
